// File: rtl/cbus_arbiter_n.sv
// Burst-holding N-way arbiter for the cache bus: merges NUM_CH masters onto one
// downstream port, fixed-priority or round-robin, releasing on last or beat count.
package cbus_pkg;

  // Burst length encodes beats minus one.
  localparam logic [7:0] MLEN1  = 8'd0;
  localparam logic [7:0] MLEN2  = 8'd1;
  localparam logic [7:0] MLEN4  = 8'd3;
  localparam logic [7:0] MLEN8  = 8'd7;
  localparam logic [7:0] MLEN16 = 8'd15;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;

endpackage

module cbus_arbiter_n
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned IDW     = $clog2(NUM_CH)
) (
  input  logic           clk,
  input  logic           resetn,
  input  cbus_req_t      ireqs  [NUM_CH],
  output cbus_resp_t     iresps [NUM_CH],
  output cbus_req_t      oreq,
  input  cbus_resp_t     oresp,
  output logic           busy,
  output logic [IDW-1:0] grant_id
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] sel_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] grant_id_q;
  logic [7:0]     beat_cnt_q;
  logic [7:0]     len_lat_q;
  logic           busy_q;

  logic           any_valid;
  logic [IDW-1:0] sel_d;
  logic [IDW-1:0] rr_ptr_d;
  logic           release_beat;

  // Search begins at rr_ptr (RR) or 0 (fixed); wrap is an explicit compare so
  // non-power-of-two channel counts stay in range.
  always_comb begin
    int unsigned start;
    int unsigned idx;
    any_valid = 1'b0;
    sel_d     = '0;
    start     = (RR_MODE != 0) ? 32'(rr_ptr_q) : 32'd0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = start + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_valid && ireqs[IDW'(idx)].valid) begin
        any_valid = 1'b1;
        sel_d     = IDW'(idx);
      end
    end
  end

  assign rr_ptr_d = (32'(sel_q) == NUM_CH - 1) ? '0 : sel_q + 1'b1;

  // Beat count guards against a downstream that never flags last.
  assign release_beat = (state_q == S_BUSY) && oresp.ready &&
                        (oresp.last || (beat_cnt_q == len_lat_q));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      len_lat_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            state_q    <= S_BUSY;
            sel_q      <= sel_d;
            len_lat_q  <= ireqs[sel_d].len;
            beat_cnt_q <= '0;
            busy_q     <= 1'b1;
            grant_id_q <= sel_d;
          end
        end
        S_BUSY: begin
          if (oresp.ready) beat_cnt_q <= beat_cnt_q + 8'd1;
          if (release_beat) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            if (RR_MODE != 0) rr_ptr_q <= rr_ptr_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    oreq = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) iresps[k] = '0;
    if (busy_q) begin
      oreq          = ireqs[sel_q];
      iresps[sel_q] = oresp;
    end
  end

  assign busy     = busy_q;
  assign grant_id = grant_id_q;

  sel_in_range: assert property (@(posedge clk) disable iff (!resetn)
    busy_q |-> (32'(sel_q) < NUM_CH));

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Scoreboard bench for cbus_arbiter_n: a round-robin and a fixed-priority instance,
// directed grant schedules and downstream beats checked by a negedge monitor.
`timescale 1ns/1ps
module tb_cbus_arbiter_n;
  import cbus_pkg::*;

  localparam int unsigned NCH = 3;

  typedef struct { int ch; int cyc_grant; int cyc_free; } grant_t;
  typedef struct { logic last; logic [31:0] rdata; } beat_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic give_last = 1'b1;

  cbus_req_t  rr_ireqs  [NCH];
  cbus_resp_t rr_iresps [NCH];
  cbus_req_t  rr_oreq;
  cbus_resp_t rr_oresp = '0;
  logic       rr_busy;
  logic [1:0] rr_gid;

  cbus_req_t  fp_ireqs  [NCH];
  cbus_resp_t fp_iresps [NCH];
  cbus_req_t  fp_oreq;
  cbus_resp_t fp_oresp = '0;
  logic       fp_busy;
  logic [1:0] fp_gid;

  grant_t rr_gq[$];
  grant_t fp_gq[$];
  beat_t  rr_bq[$];
  beat_t  fp_bq[$];

  logic   prev_b [2] = '{1'b0, 1'b0};
  logic   in_b   [2] = '{1'b0, 1'b0};
  grant_t cur    [2];

  cbus_arbiter_n #(.NUM_CH(NCH), .RR_MODE(1)) u_rr (
    .clk(clk), .resetn(resetn), .ireqs(rr_ireqs), .iresps(rr_iresps),
    .oreq(rr_oreq), .oresp(rr_oresp), .busy(rr_busy), .grant_id(rr_gid)
  );

  cbus_arbiter_n #(.NUM_CH(NCH), .RR_MODE(0)) u_fp (
    .clk(clk), .resetn(resetn), .ireqs(fp_ireqs), .iresps(fp_iresps),
    .oreq(fp_oreq), .oresp(fp_oresp), .busy(fp_busy), .grant_id(fp_gid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic quiet(input string t, input logic b, input logic [1:0] gid,
                       input cbus_req_t rq, input cbus_resp_t rs [NCH]);
    check({t, "_busy"}, 128'(b), '0);
    check({t, "_gid"}, 128'(gid), '0);
    check({t, "_oreq"}, 128'(rq), '0);
    for (int k = 0; k < NCH; k++)
      check($sformatf("%s_iresp%0d", t, k), 128'(rs[k]), '0);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic cbus_req_t mk_req(input int ch, input logic [7:0] len, input logic wr);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.addr     = 32'h1000_0000 + 32'(ch) * 32'h100;
    r.size     = 3'd2;
    r.len      = len;
    r.wdata    = 32'hC0DE_0000 + 32'(ch);
    r.wstrb    = 4'hF;
    return r;
  endfunction

  task automatic exp_rr(input int ch, input int g, input int f);
    rr_gq.push_back('{ch: ch, cyc_grant: g, cyc_free: f});
  endtask

  task automatic exp_fp(input int ch, input int g, input int f);
    fp_gq.push_back('{ch: ch, cyc_grant: g, cyc_free: f});
  endtask

  // Downstream models: one beat per busy cycle, last on the final beat unless suppressed.
  int rr_bcnt = 0, rr_seq = 0, fp_bcnt = 0, fp_seq = 0;
  always @(posedge clk) begin
    #2;
    if (!resetn || !rr_busy) begin
      rr_oresp = '0;
      if (!resetn) rr_bcnt = 0;
    end else begin
      rr_oresp.ready = 1'b1;
      rr_oresp.rdata = 32'hA000_0000 + 32'(rr_seq);
      rr_oresp.last  = give_last && (rr_bcnt == int'(rr_oreq.len));
      rr_bq.push_back('{last: rr_oresp.last, rdata: rr_oresp.rdata});
      rr_seq++;
      rr_bcnt = (rr_bcnt == int'(rr_oreq.len)) ? 0 : rr_bcnt + 1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (!resetn || !fp_busy) begin
      fp_oresp = '0;
      if (!resetn) fp_bcnt = 0;
    end else begin
      fp_oresp.ready = 1'b1;
      fp_oresp.rdata = 32'hB000_0000 + 32'(fp_seq);
      fp_oresp.last  = give_last && (fp_bcnt == int'(fp_oreq.len));
      fp_bq.push_back('{last: fp_oresp.last, rdata: fp_oresp.rdata});
      fp_seq++;
      fp_bcnt = (fp_bcnt == int'(fp_oreq.len)) ? 0 : fp_bcnt + 1;
    end
  end

  task automatic mon(input int d, input logic b, input logic [1:0] gid, input cbus_req_t rq,
                     input cbus_resp_t rs [NCH], input cbus_resp_t ds);
    string      t;
    grant_t     g;
    beat_t      bt;
    cbus_resp_t e;
    cbus_req_t  erq;
    int         qn;
    t = (d == 0) ? "rr" : "fp";
    if (!resetn) begin
      prev_b[d] = 1'b0;
      in_b[d]   = 1'b0;
      quiet({t, "_rst"}, b, gid, rq, rs);
      return;
    end
    if (b && !prev_b[d]) begin
      qn = (d == 0) ? rr_gq.size() : fp_gq.size();
      if (qn == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_unexpected_grant @cycle %0d: got ch %0d, expected no grant", t, cyc, gid);
      end else begin
        if (d == 0) g = rr_gq.pop_front();
        else        g = fp_gq.pop_front();
        cur[d]  = g;
        in_b[d] = 1'b1;
        erq     = (d == 0) ? rr_ireqs[g.ch] : fp_ireqs[g.ch];
        check({t, "_grant_id"}, 128'(gid), 128'(g.ch));
        check({t, "_grant_cycle"}, 128'(cyc), 128'(g.cyc_grant));
        check({t, "_grant_oreq"}, 128'(rq), 128'(erq));
      end
    end
    if (!b && prev_b[d] && in_b[d]) begin
      in_b[d] = 1'b0;
      if (cur[d].cyc_free >= 0)
        check({t, "_free_cycle"}, 128'(cyc), 128'(cur[d].cyc_free));
    end
    if (b && in_b[d] && ds.ready) begin
      qn = (d == 0) ? rr_bq.size() : fp_bq.size();
      if (qn == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_beat @cycle %0d: got a beat, expected none queued", t, cyc);
      end else begin
        if (d == 0) bt = rr_bq.pop_front();
        else        bt = fp_bq.pop_front();
        e = '{ready: 1'b1, last: bt.last, rdata: bt.rdata};
        for (int k = 0; k < NCH; k++)
          check($sformatf("%s_beat_iresp%0d", t, k), 128'(rs[k]),
                (k == cur[d].ch) ? 128'(e) : '0);
      end
    end
    if (!b) quiet({t, "_idle"}, b, gid, rq, rs);
    prev_b[d] = b;
  endtask

  always @(negedge clk) begin
    mon(0, rr_busy, rr_gid, rr_oreq, rr_iresps, rr_oresp);
    mon(1, fp_busy, fp_gid, fp_oreq, fp_iresps, fp_oresp);
  end

  // Reset assertion must clear outputs before any clock edge.
  always @(negedge resetn) begin
    #1;
    quiet("rr_async_rst", rr_busy, rr_gid, rr_oreq, rr_iresps);
    quiet("fp_async_rst", fp_busy, fp_gid, fp_oreq, fp_iresps);
  end

  initial begin
    #100000;
    $display("FAIL watchdog @cycle %0d: got timeout, expected end of test", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NCH; k++) begin
      rr_ireqs[k] = '0;
      fp_ireqs[k] = '0;
    end
    resetn = 1'b0;

    // Reset with all valid, then round-robin 0,1,2,0,1,2 with one dead cycle each.
    for (int k = 0; k < NCH; k++) rr_ireqs[k] = mk_req(k, MLEN1, 1'b0);
    for (int r = 0; r < 6; r++) exp_rr(r % 3, 4 + 2 * r, 5 + 2 * r);
    goto(3);
    resetn = 1'b1;
    goto(15);
    for (int k = 0; k < NCH; k++) rr_ireqs[k] = '0;

    // 16-beat read burst on ch1.
    goto(17);
    rr_ireqs[1] = mk_req(1, MLEN16, 1'b0);
    exp_rr(1, 18, 34);
    goto(34);
    rr_ireqs[1] = '0;

    // 4-beat write on ch0, downstream never flags last.
    goto(36);
    give_last   = 1'b0;
    rr_ireqs[0] = mk_req(0, MLEN4, 1'b1);
    exp_rr(0, 37, 41);
    goto(41);
    rr_ireqs[0] = '0;
    give_last   = 1'b1;

    // 8-beat burst on ch2 cut by reset at beat 3; rr_ptr was 1 before reset.
    goto(43);
    rr_ireqs[2] = mk_req(2, MLEN8, 1'b0);
    exp_rr(2, 44, -1);
    goto(46);
    #2;
    resetn = 1'b0;
    rr_bq.delete();
    rr_gq.delete();
    fp_bq.delete();
    fp_gq.delete();
    rr_ireqs[2] = '0;
    rr_ireqs[0] = mk_req(0, MLEN1, 1'b0);
    rr_ireqs[1] = mk_req(1, MLEN1, 1'b0);
    exp_rr(0, 50, 51);
    exp_rr(1, 52, 53);
    goto(49);
    resetn = 1'b1;
    goto(51);
    rr_ireqs[0] = '0;
    goto(53);
    rr_ireqs[1] = '0;

    // Fixed priority: ch0 starves ch2 until it drops valid.
    goto(55);
    fp_ireqs[0] = mk_req(0, MLEN1, 1'b0);
    fp_ireqs[2] = mk_req(2, MLEN1, 1'b0);
    for (int r = 0; r < 4; r++) exp_fp(0, 56 + 2 * r, 57 + 2 * r);
    exp_fp(2, 64, 65);
    goto(63);
    fp_ireqs[0] = '0;
    goto(65);
    fp_ireqs[2] = '0;

    goto(70);
    check("rr_grants_outstanding", 128'(rr_gq.size()), '0);
    check("fp_grants_outstanding", 128'(fp_gq.size()), '0);
    check("rr_beats_outstanding", 128'(rr_bq.size()), '0);
    check("fp_beats_outstanding", 128'(fp_bq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter_n.md
# cbus_arbiter_n

N-channel arbiter that merges several burst-capable cache-bus masters onto one downstream `cbus_req_t`/`cbus_resp_t` port. A grant is held for the whole burst and released on the beat flagged `last`. Arbitration is either fixed-priority or round-robin, selected by parameter. It sits between the ICache, DCache and uncached paths and the single AXI bridge, replacing the two-way, fixed-priority mux.

## Interface
Parameters:
- `NUM_CH`, default 2: number of upstream masters, 2..8.
- `RR_MODE`, default 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `IDW`, default `$clog2(NUM_CH)`: width of the grant index.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `ireqs`  in  `NUM_CH` x `cbus_req_t`  upstream requests.
- `iresps`  out  `NUM_CH` x `cbus_resp_t`  upstream responses.
- `oreq`  out  `cbus_req_t`  downstream request.
- `oresp`  in  `cbus_resp_t`  downstream response.
- `busy`  out  1  high while a grant is held.
- `grant_id`  out  `IDW`  index of the held grant; 0 when idle.

## Operation
- States:
  - IDLE: no grant held.
  - BUSY: grant held by channel `sel`.
- IDLE:
  - Selection considers only channels with `ireqs[i].valid`.
  - Fixed mode: pick the lowest valid index.
  - RR mode: pick the first valid index at or after `rr_ptr`, wrapping modulo `NUM_CH`.
  - If any channel is valid: register `sel` and `len_lat = ireqs[sel].len`, clear `beat_cnt`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `oreq = ireqs[sel]`, forwarded combinationally, including a `valid` drop by the master.
  - `iresps[sel] = oresp`. All other `iresps` are all-zero.
  - Each beat with `oresp.ready` increments `beat_cnt` (8-bit, compared against `len_lat`).
- Release: on the beat with `oresp.ready && (oresp.last || beat_cnt == len_lat)`:
  - Go to IDLE.
  - RR mode: `rr_ptr <= (sel + 1) mod NUM_CH`.
  - The `beat_cnt == len_lat` term guards against a downstream that never asserts `last`. The released beat is still delivered to `sel` with `last` passed through unmodified.
- Outputs in IDLE:
  - `oreq` is all-zero, so `valid = 0`.
  - All `iresps` are zero.
  - `busy = 0`, `grant_id = 0`.
- Requests arriving on other channels during BUSY are not acknowledged. They wait; masters must hold `valid` and the request fields stable until their burst ends.
- `ireqs[sel]` changing `len`, `addr` or `is_write` mid-burst is a master protocol violation. The arbiter forwards the change without checking it.

## Timing
- Reset (async assertion, while `resetn = 0`):
  - State IDLE, `sel = 0`, `rr_ptr = 0`, `beat_cnt = 0`, `len_lat = 0`.
  - All outputs zero.
- Reset release: first arbitration on the first rising edge with `resetn = 1`.
- Grant latency: valid seen in an IDLE cycle T gives BUSY and `oreq.valid` at T+1. That is one cycle of request-to-downstream latency.
- Response path: `oresp` to `iresps[sel]` is combinational, zero latency.
- Release to next grant:
  - Last beat at cycle K: IDLE at K+1, next grant visible at K+2.
  - There is always one dead cycle between bursts.
- Simultaneous requests in the same IDLE cycle resolve per mode. The losers are served in later windows.
- Reset mid-burst: immediate return to IDLE with outputs zeroed. The downstream must be reset by the same `resetn`.
- `NUM_CH` not a power of two: RR wrap uses an explicit compare with `NUM_CH-1`, not bit truncation.

## Test plan
- **Reset:** hold `resetn = 0` with all `ireqs` valid.
  - `oreq.valid = 0`, `busy = 0`, `grant_id = 0`, all `iresps` zero.
  - After release, grant to channel 0 appears one cycle later.
- **Single burst:** `NUM_CH=2`, ch1 read with `len=MLEN16`, downstream gives 16 `ready` beats, `last` on the 16th.
  - `iresps[1]` sees 16 beats. `iresps[0]` stays zero.
  - `busy` falls the cycle after beat 16.
- **Round-robin fairness:** `NUM_CH=3`, `RR_MODE=1`, all three channels continuously valid with `len=MLEN1` bursts.
  - Grant order is 0,1,2,0,1,2 with a one-cycle IDLE gap between each.
- **Fixed priority:** `NUM_CH=3`, `RR_MODE=0`, ch0 and ch2 continuously valid.
  - ch0 is granted every window; ch2 is never granted until ch0 drops `valid`, then ch2 is granted two cycles later.
- **Missing `last`:** `len=MLEN4`, downstream asserts `ready` 4 times with `last=0`.
  - Release after the 4th beat; IDLE the next cycle.
  - The 4th beat is delivered with `last=0`.
- **Reset mid-burst:** assert `resetn=0` asynchronously at beat 3 of 8.
  - Outputs go to zero without waiting for a clock edge.
  - After release, `rr_ptr=0`, so a re-requesting ch1 and ch0 resolve to ch0 first.
